// File: rtl/video_out_sequencer.sv
// video_out_sequencer: qualifies the detected input format over several frames,
// then loads a frozen timing set and enables the output timing generator and the
// frame-buffer read path. On format loss it shuts down at an output frame boundary.
// Optional build macro SEQ_TIMING_TOLERANCE_EN: vs_total/hs_total match within +/-1.
module video_out_sequencer #(
    parameter int unsigned P_STABLE_FRAMES  = 8,
    parameter int unsigned P_BLANK_FRAMES   = 2,
    parameter int unsigned P_VS_TIMEOUT_CYC = 7_425_000
) (
    input  logic         i_local_clk,
    input  logic         i_rst,
    input  logic         i_video_valid,
    input  logic [7:0]   i_resolution,
    input  logic [103:0] i_timing,
    input  logic         i_vsyn,
    input  logic         i_out_vsyn,
    output logic         o_frm_gen_enable,
    output logic         o_rd_enable,
    output logic [7:0]   o_resolution,
    output logic [103:0] o_timing,
    output logic [2:0]   o_state,
    output logic [7:0]   o_relock_cnt
);

    localparam int unsigned TMO_W = $clog2(P_VS_TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_QUALIFY = 3'd1,
        S_LOAD    = 3'd2,
        S_START   = 3'd3,
        S_RUN     = 3'd4,
        S_DRAIN   = 3'd5
    } state_t;

    state_t             state;
    logic               vs_meta, vs_sync, vs_sync_d, vs_edge;
    logic               out_vsyn_d, out_edge;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               timeout;
    logic [7:0]         stable_cnt;
    logic [3:0]         blank_cnt;
    logic [7:0]         cand_res;
    logic [103:0]       cand_timing;
    logic               match_cand, match_out, loss;

`ifdef SEQ_TIMING_TOLERANCE_EN
    function automatic logic near13(input logic [12:0] a, input logic [12:0] b);
        return (a > b) ? ((a - b) <= 13'd1) : ((b - a) <= 13'd1);
    endfunction
`endif

    function automatic logic fmt_match(input logic [7:0] ra, input logic [103:0] ta,
                                       input logic [7:0] rb, input logic [103:0] tb);
`ifdef SEQ_TIMING_TOLERANCE_EN
        return (ra == rb) && near13(ta[103:91], tb[103:91]) &&
               near13(ta[90:78], tb[90:78]) && (ta[77:0] == tb[77:0]);
`else
        return (ra == rb) && (ta == tb);
`endif
    endfunction

    // Synchronise input vsync and register single-cycle edge pulses.
    always_ff @(posedge i_local_clk) begin
        if (i_rst) begin
            vs_meta    <= 1'b0;
            vs_sync    <= 1'b0;
            vs_sync_d  <= 1'b0;
            vs_edge    <= 1'b0;
            out_vsyn_d <= 1'b0;
        end else begin
            vs_meta    <= i_vsyn;
            vs_sync    <= vs_meta;
            vs_sync_d  <= vs_sync;
            vs_edge    <= vs_sync & ~vs_sync_d;
            out_vsyn_d <= i_out_vsyn;
        end
    end

    assign out_edge   = i_out_vsyn & ~out_vsyn_d;
    assign timeout    = (tmo_cnt == TMO_W'(P_VS_TIMEOUT_CYC));
    assign match_cand = fmt_match(i_resolution, i_timing, cand_res, cand_timing);
    assign match_out  = fmt_match(i_resolution, i_timing, o_resolution, o_timing);
    assign loss       = !i_video_valid || timeout || (vs_edge && !match_out);
    assign o_state    = state;

    // Sequencer FSM with registered outputs and the shared vsync timeout counter.
    always_ff @(posedge i_local_clk) begin
        if (i_rst) begin
            state            <= S_IDLE;
            tmo_cnt          <= '0;
            stable_cnt       <= '0;
            blank_cnt        <= '0;
            cand_res         <= '0;
            cand_timing      <= '0;
            o_frm_gen_enable <= 1'b0;
            o_rd_enable      <= 1'b0;
            o_resolution     <= '0;
            o_timing         <= '0;
            o_relock_cnt     <= '0;
        end else begin
            // In DRAIN the counter measures time without an output frame edge,
            // so input vsync edges must not restart it there.
            if (vs_edge && state != S_DRAIN)
                tmo_cnt <= '0;
            else if (!timeout)
                tmo_cnt <= tmo_cnt + 1'b1;

            case (state)
                S_IDLE: begin
                    if (i_video_valid) begin
                        cand_res    <= i_resolution;
                        cand_timing <= i_timing;
                        stable_cnt  <= '0;
                        tmo_cnt     <= '0;
                        state       <= S_QUALIFY;
                    end
                end
                S_QUALIFY: begin
                    if (!i_video_valid || timeout) begin
                        tmo_cnt <= '0;
                        state   <= S_IDLE;
                    end else if (vs_edge) begin
                        if (match_cand) begin
                            if (32'(stable_cnt) + 32'd1 >= P_STABLE_FRAMES) begin
                                tmo_cnt <= '0;
                                state   <= S_LOAD;
                            end else begin
                                stable_cnt <= stable_cnt + 8'd1;
                            end
                        end else begin
                            cand_res    <= i_resolution;
                            cand_timing <= i_timing;
                            stable_cnt  <= '0;
                        end
                    end
                end
                S_LOAD: begin
                    o_timing         <= cand_timing;
                    o_resolution     <= cand_res;
                    o_frm_gen_enable <= 1'b1;
                    blank_cnt        <= '0;
                    tmo_cnt          <= '0;
                    state            <= S_START;
                end
                S_START: begin
                    if (loss) begin
                        tmo_cnt <= '0;
                        state   <= S_DRAIN;
                    end else if (P_BLANK_FRAMES == 0) begin
                        o_rd_enable <= 1'b1;
                        tmo_cnt     <= '0;
                        state       <= S_RUN;
                    end else if (out_edge) begin
                        if (32'(blank_cnt) + 32'd1 >= P_BLANK_FRAMES) begin
                            o_rd_enable <= 1'b1;
                            tmo_cnt     <= '0;
                            state       <= S_RUN;
                        end else begin
                            blank_cnt <= blank_cnt + 4'd1;
                        end
                    end
                end
                S_RUN: begin
                    if (loss) begin
                        o_rd_enable <= 1'b0;
                        tmo_cnt     <= '0;
                        state       <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    o_rd_enable <= 1'b0;
                    if (out_edge || timeout) begin
                        o_frm_gen_enable <= 1'b0;
                        if (o_relock_cnt != 8'hFF)
                            o_relock_cnt <= o_relock_cnt + 8'd1;
                        tmo_cnt <= '0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_video_out_sequencer.sv
// Directed testbench for video_out_sequencer (STABLE=4, BLANK=2, TIMEOUT=1000).
module tb_video_out_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid;
    logic [7:0]   res;
    logic [103:0] timing;
    logic         vsyn;
    logic         out_vsyn;
    logic         frm_en, rd_en;
    logic [7:0]   o_res;
    logic [103:0] o_tim;
    logic [2:0]   state;
    logic [7:0]   relock;

    int tests_run = 0;
    int tests_failed = 0;

    video_out_sequencer #(
        .P_STABLE_FRAMES(4),
        .P_BLANK_FRAMES(2),
        .P_VS_TIMEOUT_CYC(1000)
    ) dut (
        .i_local_clk(clk),
        .i_rst(rst),
        .i_video_valid(valid),
        .i_resolution(res),
        .i_timing(timing),
        .i_vsyn(vsyn),
        .i_out_vsyn(out_vsyn),
        .o_frm_gen_enable(frm_en),
        .o_rd_enable(rd_en),
        .o_resolution(o_res),
        .o_timing(o_tim),
        .o_state(state),
        .o_relock_cnt(relock)
    );

    always #5 clk = ~clk;

    function automatic logic [103:0] pack(input int vs, input int hs, input int vsn, input int hsn,
                                          input int sp, input int ep, input int sh, input int eh);
        return {13'(vs), 13'(hs), 13'(vsn), 13'(hsn), 13'(sp), 13'(ep), 13'(sh), 13'(eh)};
    endfunction

    logic [103:0] T0;
    logic [103:0] T1;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; valid = 1'b0; res = 8'h00; timing = '0; vsyn = 1'b0; out_vsyn = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic vs_pulse();
        @(negedge clk) vsyn = 1'b1;
        repeat (2) @(negedge clk);
        vsyn = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic out_pulse();
        @(negedge clk) out_vsyn = 1'b1;
        @(negedge clk) out_vsyn = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] s, input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (state == s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic bring_to_run(output bit ok);
        @(negedge clk);
        res = 8'h10; timing = T0; valid = 1'b1;
        repeat (2) @(negedge clk);
        repeat (4) vs_pulse();
        repeat (2) out_pulse();
        ok = (state == 3'd4) && rd_en && frm_en;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        tests_run++; if (state !== 3'd0) begin tests_failed++; $display("FAIL reset_state: got %0d expected 0", state); end
        tests_run++; if (frm_en !== 1'b0) begin tests_failed++; $display("FAIL reset_frm_en: got %b expected 0", frm_en); end
        tests_run++; if (rd_en !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_en: got %b expected 0", rd_en); end
        tests_run++; if (o_res !== 8'h00) begin tests_failed++; $display("FAIL reset_res: got %h expected 00", o_res); end
        tests_run++; if (o_tim !== 104'd0) begin tests_failed++; $display("FAIL reset_timing: got %h expected 0", o_tim); end
        tests_run++; if (relock !== 8'd0) begin tests_failed++; $display("FAIL reset_relock: got %0d expected 0", relock); end
    endtask

    task automatic test_lock();
        bit ok;
        do_reset();
        @(negedge clk);
        res = 8'h10; timing = T0; valid = 1'b1;
        repeat (2) @(negedge clk);
        repeat (3) vs_pulse();
        tests_run++; if (state !== 3'd1) begin tests_failed++; $display("FAIL lock_qualify3: got %0d expected 1", state); end
        @(negedge clk) vsyn = 1'b1;
        wait_state(3'd2, 8, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL lock_load: state %0d expected 2 within 8 cycles", state); end
        tests_run++; if (frm_en !== 1'b0) begin tests_failed++; $display("FAIL lock_load_frm: got %b expected 0", frm_en); end
        @(negedge clk) vsyn = 1'b0;
        tests_run++; if (state !== 3'd3) begin tests_failed++; $display("FAIL lock_start: got %0d expected 3", state); end
        tests_run++; if (frm_en !== 1'b1) begin tests_failed++; $display("FAIL lock_frm_en: got %b expected 1", frm_en); end
        tests_run++; if (o_tim !== T0) begin tests_failed++; $display("FAIL lock_timing: got %h expected %h", o_tim, T0); end
        tests_run++; if (o_res !== 8'h10) begin tests_failed++; $display("FAIL lock_res: got %h expected 10", o_res); end
        out_pulse();
        tests_run++; if (rd_en !== 1'b0 || state !== 3'd3) begin tests_failed++; $display("FAIL lock_blank1: rd %b state %0d expected rd 0 state 3", rd_en, state); end
        out_pulse();
        tests_run++; if (rd_en !== 1'b1 || state !== 3'd4) begin tests_failed++; $display("FAIL lock_run: rd %b state %0d expected rd 1 state 4", rd_en, state); end
    endtask

    task automatic test_qualify_restart();
        do_reset();
        @(negedge clk);
        res = 8'h10; timing = T0; valid = 1'b1;
        repeat (2) @(negedge clk);
        vs_pulse();
        timing = T1;
        repeat (3) vs_pulse();
`ifdef SEQ_TIMING_TOLERANCE_EN
        tests_run++; if (state !== 3'd3) begin tests_failed++; $display("FAIL qual_tol_lock: got %0d expected 3", state); end
        tests_run++; if (o_tim[90:78] !== 13'd2200) begin tests_failed++; $display("FAIL qual_tol_hs: got %0d expected 2200", o_tim[90:78]); end
`else
        tests_run++; if (state !== 3'd1) begin tests_failed++; $display("FAIL qual_restart: got %0d expected 1", state); end
        repeat (2) vs_pulse();
        tests_run++; if (state !== 3'd3) begin tests_failed++; $display("FAIL qual_relock: got %0d expected 3", state); end
        tests_run++; if (o_tim[90:78] !== 13'd2201) begin tests_failed++; $display("FAIL qual_hs: got %0d expected 2201", o_tim[90:78]); end
`endif
    endtask

    task automatic test_timeout();
        bit ok;
        do_reset();
        bring_to_run(ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL tmo_setup: state %0d expected 4", state); end
        ok = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (!rd_en) begin ok = 1'b1; break; end
        end
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL tmo_rd_drop: rd %b expected 0 within 1100 cycles", rd_en); end
        tests_run++; if (state !== 3'd5 || frm_en !== 1'b1) begin tests_failed++; $display("FAIL tmo_drain: state %0d frm %b expected 5/1", state, frm_en); end
        out_vsyn = 1'b1;
        @(negedge clk) out_vsyn = 1'b0;
        tests_run++; if (state !== 3'd0) begin tests_failed++; $display("FAIL tmo_idle: got %0d expected 0", state); end
        tests_run++; if (frm_en !== 1'b0) begin tests_failed++; $display("FAIL tmo_frm: got %b expected 0", frm_en); end
        tests_run++; if (relock !== 8'd1) begin tests_failed++; $display("FAIL tmo_relock: got %0d expected 1", relock); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_reset();
        bring_to_run(ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL drop_setup: state %0d expected 4", state); end
        @(negedge clk) vsyn = 1'b1;
        repeat (3) @(negedge clk);
        valid = 1'b0;
        tests_run++; if (rd_en !== 1'b1) begin tests_failed++; $display("FAIL drop_rd_before: got %b expected 1", rd_en); end
        @(negedge clk) vsyn = 1'b0;
        tests_run++; if (state !== 3'd5 || rd_en !== 1'b0 || frm_en !== 1'b1) begin tests_failed++; $display("FAIL drop_drain: state %0d rd %b frm %b expected 5/0/1", state, rd_en, frm_en); end
        out_pulse();
        tests_run++; if (state !== 3'd0 || relock !== 8'd1) begin tests_failed++; $display("FAIL drop_idle: state %0d relock %0d expected 0/1", state, relock); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bring_to_run(ok);
        tests_run++; if (!ok || relock !== 8'd1) begin tests_failed++; $display("FAIL rstmid_setup: state %0d relock %0d expected 4/1", state, relock); end
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        tests_run++; if (state !== 3'd0) begin tests_failed++; $display("FAIL rstmid_state: got %0d expected 0", state); end
        tests_run++; if (frm_en !== 1'b0 || rd_en !== 1'b0) begin tests_failed++; $display("FAIL rstmid_en: frm %b rd %b expected 0/0", frm_en, rd_en); end
        tests_run++; if (o_tim !== 104'd0 || o_res !== 8'h00) begin tests_failed++; $display("FAIL rstmid_fmt: tim %h res %h expected 0", o_tim, o_res); end
        tests_run++; if (relock !== 8'd0) begin tests_failed++; $display("FAIL rstmid_relock: got %0d expected 0", relock); end
    endtask

    task automatic test_relock_saturate();
        bit ok;
        int lock_fail = 0;
        do_reset();
        res = 8'h22; timing = T0;
        for (int k = 1; k <= 256; k++) begin
            @(negedge clk) valid = 1'b1;
            repeat (4) begin
                @(negedge clk) vsyn = 1'b1;
                @(negedge clk) vsyn = 1'b0;
                repeat (3) @(negedge clk);
            end
            wait_state(3'd3, 6, ok);
            if (!ok) lock_fail++;
            valid = 1'b0;
            @(negedge clk) out_vsyn = 1'b1;
            @(negedge clk) out_vsyn = 1'b0;
            @(negedge clk);
            if (state != 3'd0) lock_fail++;
            if (k == 200) begin
                tests_run++; if (relock !== 8'd200) begin tests_failed++; $display("FAIL sat_200: got %0d expected 200", relock); end
            end
            if (k == 255) begin
                tests_run++; if (relock !== 8'd255) begin tests_failed++; $display("FAIL sat_255: got %0d expected 255", relock); end
            end
        end
        tests_run++; if (relock !== 8'd255) begin tests_failed++; $display("FAIL sat_256: got %0d expected 255", relock); end
        tests_run++; if (lock_fail !== 0) begin tests_failed++; $display("FAIL sat_cycles: got %0d bad cycles expected 0", lock_fail); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; valid = 1'b0; res = '0; timing = '0; vsyn = 1'b0; out_vsyn = 1'b0;
        T0 = pack(1125, 2200, 5, 44, 192, 2112, 41, 1121);
        T1 = pack(1125, 2201, 5, 44, 192, 2112, 41, 1121);
        test_reset();
        test_lock();
        test_qualify_restart();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_relock_saturate();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/video_out_sequencer.md
Name: video_out_sequencer

Overview:
- Local-clock controller that qualifies the detected input video format and sequences the output timing generator and the frame-buffer read path.
- Takes video_valid, resolution and the packed timing fields from the judgement/detect stage; requires N consistent frames before acting.
- Loads a frozen timing set, enables frame generation, then enables DDR reads after blank frames.
- On format loss it shuts down at an output frame boundary, so downstream never sees a torn frame.

Parameters:
- P_STABLE_FRAMES, 8: consecutive identical input frames required before lock (1..255).
- P_BLANK_FRAMES, 2: output frames generated with reads disabled after start (0..15).
- P_VS_TIMEOUT_CYC, 7_425_000: local cycles without a vsync edge that count as signal loss (50 ms at 148.5 MHz); counter width is clog2 of this value.

Ports:
- i_local_clk  in  1  system clock, all logic on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_video_valid  in  1  format-valid flag from judgement (local domain).
- i_resolution  in  8  detected resolution code.
- i_timing  in  104  packed {vs_total, hs_total, vsyn_num, hsyn_num, start_pixel, end_pixel, start_H, end_H}, 13 b each, vs_total in MSBs.
- i_vsyn  in  1  input vsync, asynchronous; synchronised internally.
- i_out_vsyn  in  1  output-timing vsync from the generator (local domain).
- o_frm_gen_enable  out  1  timing generator enable.
- o_rd_enable  out  1  frame-buffer read enable.
- o_resolution  out  8  frozen resolution.
- o_timing  out  104  frozen timing, same packing as i_timing.
- o_state  out  3  current state code.
- o_relock_cnt  out  8  count of lock losses, saturating.

Behaviour:
Reset:
- All outputs 0; state IDLE; all counters 0.
- Assertion mid-operation drops both enables on the next edge; no drain.

Edge detection:
- i_vsyn passes through a 2-flop synchroniser plus an edge register.
- vs_edge is a 1-cycle pulse, 3 cycles after the i_vsyn rise.
- out_edge is the rising edge of i_out_vsyn, 1 cycle latency.

Timeout counter:
- Clears on vs_edge and on every state entry; otherwise increments, saturating.
- timeout is true when the count reaches P_VS_TIMEOUT_CYC.

States (o_state code):
- IDLE(0): wait for i_video_valid=1. On it, snapshot resolution and timing into cand, clear stable_cnt, go to QUALIFY.
- QUALIFY(1): if i_video_valid=0 or timeout, go to IDLE. On vs_edge: if inputs match cand, stable_cnt+1; else re-snapshot cand and set stable_cnt=0. When stable_cnt reaches P_STABLE_FRAMES, go to LOAD.
- LOAD(2): one cycle. o_timing and o_resolution take cand. Go to START.
- START(3): o_frm_gen_enable=1 from entry. Count out_edge. On the P_BLANK_FRAMES-th out_edge go to RUN; if P_BLANK_FRAMES=0, go to RUN on the next cycle. A loss condition (same as RUN) goes to DRAIN.
- RUN(4): o_rd_enable=1. Loss is any of: i_video_valid=0, timeout, or a vs_edge with inputs differing from o_timing/o_resolution. Loss goes to DRAIN.
- DRAIN(5): o_rd_enable=0 on entry. On out_edge, or after P_VS_TIMEOUT_CYC cycles with no out_edge, clear o_frm_gen_enable, increment o_relock_cnt (saturates at 255), go to IDLE.

Rules:
- Outputs are registered and change the cycle after the state transition.
- Simultaneous valid drop and vs_edge: the drop wins.
- o_timing and o_resolution hold their last values after DRAIN until the next LOAD.

Optional Feature:
- Macro SEQ_TIMING_TOLERANCE_EN.
- Defined: vs_total and hs_total compare equal within ±1 (absolute difference ≤ 1, 13-bit unsigned). All other fields, and resolution, compare exactly.
- Undefined: all 104 timing bits and the resolution must match exactly.

Test Plan (bench: P_STABLE_FRAMES=4, P_BLANK_FRAMES=2, P_VS_TIMEOUT_CYC=1000):
- Valid=1, res=0x10, 4 identical input vsyncs → LOAD after the 4th vs_edge. o_frm_gen_enable=1 one cycle after LOAD. o_rd_enable=1 after the 2nd out_edge.
- In QUALIFY, hs_total 2200→2201 at the 2nd vsync → stable_cnt restarts. Lock needs 4 further matching frames. With SEQ_TIMING_TOLERANCE_EN, lock occurs at the original 4th frame.
- In RUN, i_vsyn stops → after 1000 cycles o_rd_enable=0. o_frm_gen_enable drops on the next out_edge; o_relock_cnt=1; state IDLE.
- In RUN, valid drops on the same cycle as a vs_edge → DRAIN entered; o_rd_enable falls next cycle.
- i_rst pulsed in RUN → next cycle all outputs 0, state 0, o_relock_cnt=0.
- 256 forced lock losses → o_relock_cnt saturates at 255.
